// File: rtl/pipe_elastic_chain_pkg.sv
// Shared definitions for the elastic pipeline register fabric: width helper,
// default datapath widths and stage indices of the 5-stage core.
package pipe_elastic_chain_pkg;

    localparam int NB_REG   = 32;
    localparam int NB_INSTR = 32;

    // Stage indices when the chain is built with N_STAGES = 5
    localparam int IF  = 0;
    localparam int ID  = 1;
    localparam int EX  = 2;
    localparam int MEM = 3;
    localparam int WB  = 4;

    // Bits needed to encode values 0..value-1 (at least 1)
    function automatic int clogb2(input int value);
        int remaining;
        int bits;
        bits      = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            bits      = bits + 1;
            remaining = remaining >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/pipe_elastic_chain_stage.sv
// One slot of the elastic chain: a valid bit plus payload, loaded from its
// upstream source when it is empty or being drained, killed by flush, and
// frozen entirely while the chain is disabled.
module pipe_elastic_stage
    import pipe_elastic_chain_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_freeze,
    input  logic               i_src_valid,
    input  logic [NB_DATA-1:0] i_src_data,
    input  logic               i_dn_rdy,
    input  logic               i_flush,
    output logic               o_rdy,
    output logic               o_vld,
    output logic               o_vld_next,
    output logic [NB_DATA-1:0] o_data
);

    logic               vld_q;
    logic               vld_d;
    logic [NB_DATA-1:0] data_q;
    logic [NB_DATA-1:0] data_d;

    // Next slot contents: load or drain when ready, flush overrides, freeze holds everything
    always_comb begin
        o_rdy  = !vld_q || i_dn_rdy;
        vld_d  = vld_q;
        data_d = data_q;
        if (!i_freeze) begin
            if (o_rdy) begin
                vld_d = i_src_valid;
                if (i_src_valid) begin
                    data_d = i_src_data;
                end
            end
            if (i_flush) begin
                vld_d = 1'b0;
            end
        end
    end

    // Slot register with synchronous reset
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign o_vld      = vld_q;
    assign o_vld_next = i_reset ? 1'b0 : vld_d;
    assign o_data     = data_q;

endmodule

// File: rtl/pipe_elastic_chain.sv
// Elastic valid/ready register chain of N_STAGES slots with per-stage flush,
// global freeze (i_valid low) and registered occupancy.
// Optional statistics counters are compiled in with PIPE_ELASTIC_STATS_EN.
module pipe_elastic_chain
    import pipe_elastic_chain_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int N_STAGES = 5,
    parameter int NB_OCC   = clogb2(N_STAGES + 1),
    parameter int NB_CNT   = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [NB_DATA-1:0]  i_in_data,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [NB_DATA-1:0]  o_out_data,
    input  logic [N_STAGES-1:0] i_flush,
    output logic [N_STAGES-1:0] o_stage_valid,
    output logic [NB_OCC-1:0]   o_occupancy
`ifdef PIPE_ELASTIC_STATS_EN
    ,
    output logic [NB_CNT-1:0]   o_n_clocks,
    output logic [NB_CNT-1:0]   o_n_stalls
`endif
);

    logic [N_STAGES:0]   rdy;
    logic [N_STAGES-1:0] vld;
    logic [N_STAGES-1:0] vld_next;
    logic [NB_DATA-1:0]  data [N_STAGES];
    logic                in_ready;
    logic [NB_OCC-1:0]   occ_q;
    logic [NB_OCC-1:0]   occ_d;

    assign rdy[N_STAGES] = i_out_ready;

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        logic               src_valid;
        logic [NB_DATA-1:0] src_data;

        if (k == 0) begin : g_head
            assign src_valid = i_in_valid;
            assign src_data  = i_in_data;
        end else begin : g_body
            // A flushed upstream slot hands over nothing, so its item cannot
            // slip past the flush by moving forward in the same cycle.
            assign src_valid = vld[k-1] & ~i_flush[k-1];
            assign src_data  = data[k-1];
        end

        pipe_elastic_stage #(
            .NB_DATA (NB_DATA)
        ) u_stage (
            .i_clock     (i_clock),
            .i_reset     (i_reset),
            .i_freeze    (~i_valid),
            .i_src_valid (src_valid),
            .i_src_data  (src_data),
            .i_dn_rdy    (rdy[k+1]),
            .i_flush     (i_flush[k]),
            .o_rdy       (rdy[k]),
            .o_vld       (vld[k]),
            .o_vld_next  (vld_next[k]),
            .o_data      (data[k])
        );
    end

    assign in_ready      = rdy[0] & i_valid & ~i_reset;
    assign o_in_ready    = in_ready;
    assign o_out_valid   = vld[N_STAGES-1] & ~i_flush[N_STAGES-1] & i_valid;
    assign o_out_data    = data[N_STAGES-1];
    assign o_stage_valid = vld;
    assign o_occupancy   = occ_q;

    // Occupancy tracks the popcount of the slot valid bits as they will be after this edge
    always_comb begin
        occ_d = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            if (vld_next[k]) begin
                occ_d = occ_d + NB_OCC'(1);
            end
        end
    end

    // Occupancy register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef PIPE_ELASTIC_STATS_EN
    logic [NB_CNT-1:0] n_clocks_q;
    logic [NB_CNT-1:0] n_clocks_d;
    logic [NB_CNT-1:0] n_stalls_q;
    logic [NB_CNT-1:0] n_stalls_d;

    // Count enabled edges and enabled edges where an offered item was refused
    always_comb begin
        n_clocks_d = n_clocks_q;
        n_stalls_d = n_stalls_q;
        if (i_valid) begin
            n_clocks_d = n_clocks_q + NB_CNT'(1);
            if (i_in_valid && !in_ready) begin
                n_stalls_d = n_stalls_q + NB_CNT'(1);
            end
        end
    end

    // Statistics registers, wrapping naturally
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            n_clocks_q <= '0;
            n_stalls_q <= '0;
        end else begin
            n_clocks_q <= n_clocks_d;
            n_stalls_q <= n_stalls_d;
        end
    end

    assign o_n_clocks = n_clocks_q;
    assign o_n_stalls = n_stalls_q;
`else
    // NB_CNT only sizes the statistics counters; referenced here so the
    // parameter list is identical in both builds.
    if (NB_CNT < 1) begin : g_nb_cnt_unused
    end
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed bench for pipe_elastic_chain (N_STAGES=5, NB_DATA=32).
module tb_pipe_elastic_chain;

    localparam int NB_DATA  = 32;
    localparam int N_STAGES = 5;
    localparam int NB_OCC   = 3;
    localparam int NB_CNT   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                in_valid;
    logic                in_ready;
    logic [NB_DATA-1:0]  in_data;
    logic                out_valid;
    logic                out_ready;
    logic [NB_DATA-1:0]  out_data;
    logic [N_STAGES-1:0] flush;
    logic [N_STAGES-1:0] stage_valid;
    logic [NB_OCC-1:0]   occ;
`ifdef PIPE_ELASTIC_STATS_EN
    logic [NB_CNT-1:0]   n_clocks;
    logic [NB_CNT-1:0]   n_stalls;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pipe_elastic_chain #(
        .NB_DATA  (NB_DATA),
        .N_STAGES (N_STAGES),
        .NB_OCC   (NB_OCC),
        .NB_CNT   (NB_CNT)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_valid       (en),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .i_flush       (flush),
        .o_stage_valid (stage_valid),
        .o_occupancy   (occ)
`ifdef PIPE_ELASTIC_STATS_EN
        ,
        .o_n_clocks    (n_clocks),
        .o_n_stalls    (n_stalls)
`endif
    );

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic [4:0]  fl;
        logic        en;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [4:0]  e_sv;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic [4:0] fl, input logic e);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        en        = e;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int got;
        int first_cyc;
        int sent;
        logic pushed;
        logic [31:0] exp_q[$];

        rst = 1'b1;
        drive(1'b1, 32'hDEAD, 1'b1, 5'b11111, 1'b1);
        tick();
        tick();
        #1;
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset stage_valid", stage_valid, 5'b0);
        chk("reset occupancy", occ, 3'd0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b1);
        tick();

        // ---- table: fill, full, pop+push, freeze, resume
        //                 iv   din    ordy  flush     en    ir    ov    od     sv         occ
        tbl.push_back(vec_t'{1'b1, 32'h1, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 32'h0, 5'b00000, 3'd0});
        tbl.push_back(vec_t'{1'b1, 32'h2, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 32'h0, 5'b00001, 3'd1});
        tbl.push_back(vec_t'{1'b1, 32'h3, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 32'h0, 5'b00011, 3'd2});
        tbl.push_back(vec_t'{1'b1, 32'h4, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 32'h0, 5'b00111, 3'd3});
        tbl.push_back(vec_t'{1'b1, 32'h5, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b0, 32'h0, 5'b01111, 3'd4});
        tbl.push_back(vec_t'{1'b1, 32'h6, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h1, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b0, 32'h0, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h2, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b0, 32'h0, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h3, 5'b11110, 3'd4});
        tbl.push_back(vec_t'{1'b1, 32'h7, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h3, 5'b11110, 3'd4});
        tbl.push_back(vec_t'{1'b1, 32'h8, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, 32'h3, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b1, 32'h8, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h3, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b1, 32'h9, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 32'h4, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b1, 32'h9, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, 32'h4, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b0, 32'h0, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h4, 5'b11111, 3'd5});
        tbl.push_back(vec_t'{1'b0, 32'h0, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h5, 5'b11110, 3'd4});
        tbl.push_back(vec_t'{1'b0, 32'h0, 1'b1, 5'b00000, 1'b1, 1'b1, 1'b1, 32'h6, 5'b11100, 3'd3});

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].iv, tbl[i].din, tbl[i].ordy, tbl[i].fl, tbl[i].en);
            #1;
            chk($sformatf("row%0d in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
            chk($sformatf("row%0d out_data", i), out_data, tbl[i].e_od);
            chk($sformatf("row%0d stage_valid", i), stage_valid, tbl[i].e_sv);
            chk($sformatf("row%0d occupancy", i), occ, tbl[i].e_occ);
            tick();
        end

        // ---- stream 0x1..0xA at full rate: first output 5 cycles after first accept
        do_reset();
        got = 0;
        sent = 0;
        first_cyc = -1;
        for (int c = 0; c < 40 && got < 10; c++) begin
            drive(sent < 10, 32'(sent + 1), 1'b1, 5'b0, 1'b1);
            #1;
            if (sent < 10) begin
                chk($sformatf("stream in_ready c%0d", c), in_ready, 1'b1);
                sent++;
            end
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = c;
                chk($sformatf("stream data #%0d", got), out_data, 32'(got + 1));
                chk($sformatf("stream cycle #%0d", got), 64'(c), 64'(5 + got));
                got++;
            end
            tick();
        end
        chk("stream count", 64'(got), 64'd10);
        chk("stream latency", 64'(first_cyc), 64'd5);

        // ---- flush of stages 1 and 2 in a stalled full chain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h14 - 32'(i), 1'b0, 5'b0, 1'b1);
            #1;
            chk($sformatf("fill in_ready %0d", i), in_ready, 1'b1);
            tick();
        end
        drive(1'b1, 32'h55, 1'b0, 5'b0, 1'b1);
        #1;
        chk("full in_ready", in_ready, 1'b0);
        chk("full occupancy", occ, 3'd5);
        chk("full out_data", out_data, 32'h14);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'b00110, 1'b1);
        #1;
        chk("flush out_valid", out_valid, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b1);
        #1;
        chk("post-flush stage_valid", stage_valid, 5'b11001);
        chk("post-flush occupancy", occ, 3'd3);
        exp_q = '{32'h14, 32'h13, 32'h10, 32'h20};
        got = 0;
        pushed = 1'b0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            drive(!pushed, 32'h20, 1'b1, 5'b0, 1'b1);
            #1;
            if (in_valid && in_ready) pushed = 1'b1;
            if (out_valid) begin
                chk($sformatf("flush drain #%0d", got), out_data, exp_q[got]);
                got++;
            end
            tick();
        end
        chk("flush drain count", 64'(got), 64'd4);

        // ---- reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA1 + 32'(i), 1'b0, 5'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b1);
        #1;
        chk("pre-reset stage_valid", stage_valid, 5'b00111);
        chk("pre-reset occupancy", occ, 3'd3);
        rst = 1'b1;
        drive(1'b1, 32'hBB, 1'b1, 5'b0, 1'b1);
        #1;
        chk("mid-reset in_ready", in_ready, 1'b0);
        tick();
        chk("after reset stage_valid", stage_valid, 5'b0);
        chk("after reset occupancy", occ, 3'd0);
        chk("after reset out_valid", out_valid, 1'b0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 5'b0, 1'b1);
        tick();
        chk("reset item dropped", stage_valid, 5'b0);

`ifdef PIPE_ELASTIC_STATS_EN
        // ---- statistics: 10 enabled edges, 4 refused offers, 2 frozen edges
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h30 + 32'(i), 1'b0, 5'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h40, 1'b0, 5'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h40, 1'b0, 5'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 5'b0, 1'b0);
        #1;
        chk("stats n_clocks", n_clocks, 32'd10);
        chk("stats n_stalls", n_stalls, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_elastic_chain.md
Name: pipe_elastic_chain

Overview:
- Parametrised elastic pipeline register chain with N_STAGES stages and a valid/ready handshake between adjacent stages.
- Per-stage flush mask, global freeze via i_valid, and occupancy reporting.
- Generalises the fixed inter-stage latches of the 5-stage MIPS core so depth and width are parameters and backpressure is native.
- Intended as the inter-stage register fabric (IF/ID ... MEM/WB) and for instrumentation paths.

Parameters:
- NB_DATA, 32, payload width per stage.
- N_STAGES, 5, number of register stages (>=1).
- NB_OCC, clogb2(N_STAGES+1), occupancy counter width.
- NB_CNT, 32, statistics counter width (used only with the optional feature).

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  global enable; low freezes the chain.
- i_in_valid  in  1  upstream item present.
- o_in_ready  out  1  chain accepts the upstream item this cycle.
- i_in_data  in  NB_DATA  upstream payload.
- o_out_valid  out  1  last stage holds a valid item.
- i_out_ready  in  1  downstream accepts.
- o_out_data  out  NB_DATA  last-stage payload.
- i_flush  in  N_STAGES  bit k kills stage k's contents.
- o_stage_valid  out  N_STAGES  valid bit per stage.
- o_occupancy  out  NB_OCC  count of valid stages.

Behaviour:
- State: data_q[k] (NB_DATA) and vld_q[k] for k = 0..N_STAGES-1. Stage 0 is nearest the input.
- Reset (synchronous, i_reset=1 at an edge):
  - all vld_q = 0, all data_q = 0.
  - Outputs: o_out_valid=0, o_out_data=0, o_stage_valid=0, o_occupancy=0.
  - o_in_ready=0 while i_reset is high.
  - Reset overrides i_valid and i_flush.
- Ready chain (combinational):
  - rdy[N_STAGES] = i_out_ready.
  - rdy[k] = !vld_q[k] || rdy[k+1].
  - o_in_ready = rdy[0] & i_valid & !i_reset.
- o_out_valid = vld_q[N-1] & !i_flush[N-1] & i_valid.
- o_out_data = data_q[N-1], always driven.
- Transfer into stage k at an edge: requires i_valid and rdy[k], with source valid.
  - The source is stage k-1, or i_in_valid for k=0.
  - data_q[k] takes the source data; vld_q[k] takes the source valid.
- If the stage does not transfer, it holds. A stage emptied by its downstream with no incoming item clears vld_q[k].
- Flush: vld_q[k] at the next edge is forced to 0 when i_flush[k] is 1.
  - Flush takes priority over load and hold.
  - An item moving from stage k-1 into a flushed stage k is discarded.
  - Stage k-1 still sees the transfer as accepted, so nothing is duplicated.
  - Flushed stages do not assert backpressure; rdy is computed from pre-flush vld_q.
  - A flushed last stage produces no output handshake that cycle.
  - data_q is not cleared by flush.
- Freeze: while i_valid=0, no register changes (flush included), o_in_ready=0, o_out_valid=0.
- Latency: an item entering an empty chain appears at o_out_valid N_STAGES cycles after acceptance.
- Throughput: 1 item/cycle when i_out_ready is held high.
- Full: all vld_q=1 and i_out_ready=0 gives o_in_ready=0. Simultaneous pop and push when full is allowed; occupancy stays N_STAGES.
- o_occupancy = popcount(vld_q), registered state, updated the cycle after each change.
- N_STAGES=1 degenerates to a single register with ready pass-through.

Optional Feature:
- Macro PIPE_ELASTIC_STATS_EN.
- When defined, adds outputs:
  - o_n_clocks [NB_CNT]: counts edges with i_valid=1.
  - o_n_stalls [NB_CNT]: counts edges where i_in_valid=1, i_valid=1 and o_in_ready=0.
  - Both are zeroed by i_reset and wrap at 2^NB_CNT.
- When undefined, these ports and counters do not exist and the remaining behaviour is identical.

Decomposition:
- Shared package holds:
  - clogb2 function.
  - Default widths (NB_REG=32, NB_INSTR=32).
  - Stage-index localparams IF=0, ID=1, EX=2, MEM=3, WB=4 for the 5-stage instantiation.
- One sub-module, pipe_elastic_stage: single register slot with vld/data, load/flush/freeze inputs and rdy output. The chain is generate-instantiated from it.

Test Plan:
- Reset then stream 0x1..0xA with i_out_ready=1, N_STAGES=5 → first o_out_valid 5 cycles after the first accept; outputs 0x1..0xA in order, one per cycle.
- Fill with 5 items, i_out_ready=0 → o_in_ready=0 and o_occupancy=5. Then raise i_out_ready while pushing 0x55 in the same cycle → pop and push both occur, occupancy stays 5.
- Chain holds 0x10..0x14 (0x14 in stage 4, 0x10 in stage 0), pulse i_flush=5'b00110 for one cycle → 0x11 and 0x12 are lost. Output order is 0x14, 0x13, 0x10, then subsequent items; occupancy drops by 2.
- i_valid=0 for 3 cycles mid-stream with i_flush=all-ones and i_in_valid=1 → no state change, o_in_ready=0, o_out_valid=0. Resume → stream continues with no loss.
- Assert i_reset mid-stream with occupancy 3 → next cycle all vld_q=0 and o_occupancy=0; an item presented during reset is not accepted.
- With PIPE_ELASTIC_STATS_EN: 10 enabled cycles, 4 of them with blocked input → o_n_clocks=10, o_n_stalls=4.
